row_buff_reader: RTL and testbench

Read-side controller for the single-row pixel line buffer: consumes "row complete" credits from the writer side and drains each row out of the buffer. It drives the buffer's read strobe and absorbs its 1-cycle read latency in a 2-entry skid FIFO. It presents the row as an AXI4-Stream master with tlast at end of row and tuser at start of frame. It sits between the row buffer and the downstream fusion/filter stage, which may apply backpressure.

---
 rtl/row_buff_reader.sv | 205 ++++++++++++++++++++
 tb/tb_row_buff_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_buff_reader.sv
// -----------------------------------------------------------------------------
// row_buff_reader
//
// Read-side controller for a single-row pixel line buffer. Row-complete
// credits from the writer are queued; each credit drains one row of
// BEATS = IMAGE_DIM / PIXELS_PER_BEAT beats out of the buffer in address
// order. The buffer's 1-cycle read latency is absorbed by a 2-entry skid
// FIFO that feeds an AXI4-Stream master port (tlast = last beat of a row,
// tuser = first beat of a frame).
//
// Ports:
//   clk, aresetn     clock, asynchronous active-low reset
//   row_done         1-cycle pulse: one full row written to the buffer
//   buf_rd_en        read strobe to the buffer (data returns next cycle)
//   buf_rd_data      buffer read data, valid the cycle after buf_rd_en
//   m_axis_t*        AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   busy             controller is not idle
//   credit_overflow  sticky: a row_done was dropped because the queue was full
//   stall_cycles     cycles with tvalid=1 and tready=0 (optional)
//
// Build option: define ROW_READER_STATS_EN to enable the saturating
// stall_cycles counter; otherwise stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module row_buff_reader #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int MAX_PENDING     = 2
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  row_done,
    output logic                  buf_rd_en,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  credit_overflow,
    output logic [31:0]           stall_cycles
);

    localparam int BEATS  = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W  = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
    localparam int CRED_W = $clog2(MAX_PENDING + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMAGE_DIM - 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    // One skid entry: the beat plus the framing flags decided at issue time.
    typedef struct packed {
        logic                  first;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t            state, state_next;
    logic [CRED_W-1:0] credits;
    logic [BEAT_W-1:0] issue_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              rd_inflight, rd_last, rd_first;
    entry_t            fifo_mem [2];
    logic              fifo_rd_ptr, fifo_wr_ptr;
    logic [1:0]        fifo_count;
    logic              consume, pop, push, head_last;
    logic [2:0]        slots_used;

    assign pop       = m_axis_tvalid && m_axis_tready;
    assign push      = rd_inflight;
    assign head_last = fifo_mem[fifo_rd_ptr].last;

    // Skid slots claimed next cycle if no new read is issued now. Counting
    // the slot freed by this cycle's pop is what allows one strobe per cycle
    // under tready=1; it also makes buf_rd_en combinational on m_axis_tready.
    assign slots_used = 3'(fifo_count) - 3'(pop) + 3'(rd_inflight);

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        buf_rd_en  = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (credits != '0) begin
                    state_next = STREAM;
                    consume    = 1'b1;
                end
            end
            STREAM: begin
                if (slots_used < 3'd2) begin
                    buf_rd_en = 1'b1;
                    if (issue_cnt == LAST_BEAT) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    // A row_done in this same cycle is good enough to chain.
                    if (credits != '0 || row_done) begin
                        state_next = STREAM;
                        consume    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    // Credit queue: a simultaneous consume and row_done leaves it unchanged.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            credits         <= '0;
            credit_overflow <= 1'b0;
        end else if (consume && !row_done) begin
            credits <= credits - CRED_W'(1);
        end else if (row_done && !consume) begin
            if (credits == CRED_MAX) credit_overflow <= 1'b1;
            else                     credits <= credits + CRED_W'(1);
        end
    end

    // Read issue side: the in-flight flag and its framing tags mirror the
    // buffer's 1-cycle latency so the data lands in the skid with them.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            issue_cnt   <= '0;
            rd_inflight <= 1'b0;
            rd_last     <= 1'b0;
            rd_first    <= 1'b0;
        end else begin
            rd_inflight <= buf_rd_en;
            if (buf_rd_en) begin
                rd_last  <= (issue_cnt == LAST_BEAT);
                rd_first <= (issue_cnt == '0) && (row_cnt == '0);
            end
            if (consume)        issue_cnt <= '0;
            else if (buf_rd_en) issue_cnt <= issue_cnt + BEAT_W'(1);
        end
    end

    // Row counter advances on the tlast handshake; a new row is only issued
    // after that, so issue-time row_cnt always names the row being read.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)              row_cnt <= '0;
        else if (pop && head_last) row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ROW_W'(1);
    end

    // NOTE: the skid storage is reset because its head drives tdata/tlast/
    // tuser directly, and those outputs must read zero during reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= '{first: rd_first, last: rd_last, data: buf_rd_data};
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = fifo_mem[fifo_rd_ptr].data;
    assign m_axis_tlast  = m_axis_tvalid && head_last;
    assign m_axis_tuser  = m_axis_tvalid && fifo_mem[fifo_rd_ptr].first;
    assign busy          = (state != IDLE);

`ifdef ROW_READER_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)                                          stall_q <= '0;
        else if (m_axis_tvalid && !m_axis_tready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_row_buff_reader.sv
// -----------------------------------------------------------------------------
// tb_row_buff_reader
//
// Scoreboard bench for row_buff_reader (IMAGE_DIM=64, 16 pixels/beat, so
// 4 beats per row). Every accepted row_done pushes that row's four beats,
// with their expected tlast/tuser, into a queue; the monitor pops one entry
// per output handshake and also checks that a stalled beat is held stable.
// A small behavioural row-buffer model answers the read strobes.
// -----------------------------------------------------------------------------
module tb_row_buff_reader;

    localparam int PPB   = 16;
    localparam int DIM   = 64;
    localparam int DW    = 8 * PPB;
    localparam int MAXP  = 2;
    localparam int BEATS = DIM / PPB;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          row_done;
    logic          buf_rd_en;
    logic [DW-1:0] buf_rd_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          busy;
    logic          credit_overflow;
    logic [31:0]   stall_cycles;

    always #5 clk = ~clk;

    row_buff_reader #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM      (DIM),
        .DATA_WIDTH     (DW),
        .MAX_PENDING    (MAXP)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .row_done       (row_done),
        .buf_rd_en      (buf_rd_en),
        .buf_rd_data    (buf_rd_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .busy           (busy),
        .credit_overflow(credit_overflow),
        .stall_cycles   (stall_cycles)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t         exp_q [$];
    logic [DW-1:0] row_mem [256][BEATS];
    int            wr_row     = 0;  // rows written into the buffer model
    int            model_row  = 0;  // frame row index of the next accepted row
    int            total      = 0;
    int            bad        = 0;
    int            rows_out   = 0;  // tlast handshakes seen
    int            hs_cnt     = 0;  // beat handshakes seen
    int            user_seen  = 0;
    int            stall_seen = 0;  // cycles seen with tvalid=1, tready=0

    task automatic check(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row buffer model: sequential addresses, one row at a time, read data
    // one cycle after the strobe. Reset realigns it to the next written row.
    int rd_row  = 0;
    int rd_addr = 0;
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_addr     <= 0;
            rd_row      <= wr_row;
            buf_rd_data <= '0;
        end else if (buf_rd_en) begin
            buf_rd_data <= row_mem[rd_row % 256][rd_addr];
            if (rd_addr == BEATS - 1) begin
                rd_addr <= 0;
                rd_row  <= rd_row + 1;
            end else begin
                rd_addr <= rd_addr + 1;
            end
        end
    end

    // Monitor: scoreboard compare on every handshake, hold check on stalls.
    initial begin
        beat_t got;
        beat_t exp;
        beat_t held_beat;
        logic  held;
        held      = 1'b0;
        held_beat = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                held = 1'b0;
            end else begin
                got = '{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser};
                if (held) begin
                    check("hold_tvalid", (DW+2)'(m_axis_tvalid), (DW+2)'(1));
                    check("hold_beat", got, held_beat);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cnt++;
                    check("beat_expected", (DW+2)'(exp_q.size() != 0), (DW+2)'(1));
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("tdata", (DW+2)'(got.data), (DW+2)'(exp.data));
                        check("tlast", (DW+2)'(got.last), (DW+2)'(exp.last));
                        check("tuser", (DW+2)'(got.user), (DW+2)'(exp.user));
                    end
                    if (got.last) rows_out++;
                    if (got.user) user_seen++;
                    held = 1'b0;
                end else if (m_axis_tvalid) begin
                    stall_seen++;
                    held      = 1'b1;
                    held_beat = got;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One row_done pulse; an accepted row gets fresh buffer content and its
    // expected beats. tuser belongs to beat 0 of frame row 0.
    task automatic send_row(input logic accepted);
        logic [DW-1:0] d;
        row_done = 1'b1;
        if (accepted) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
                row_mem[wr_row % 256][b] = d;
                exp_q.push_back('{data: d, last: (b == BEATS - 1), user: (b == 0) && (model_row == 0)});
            end
            wr_row++;
            model_row = (model_row + 1) % DIM;
        end
        tick();
        row_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy) && n < bound) begin
            tick();
            n++;
        end
        check(name, (DW+2)'(exp_q.size() == 0 && !busy), (DW+2)'(1));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        exp_q.delete();
        model_row = 0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        int   first_busy, first_valid, first_rd, last_rd, rd_cnt;
        int   hs0, rows0, user0, sent, cyc;
        int   s0, w0;
        logic timeout;
        logic [3:0] pat;

        aresetn       = 1'b0;
        row_done      = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_tvalid", (DW+2)'(m_axis_tvalid), '0);
        check("rst_tdata", (DW+2)'(m_axis_tdata), '0);
        check("rst_tlast", (DW+2)'(m_axis_tlast), '0);
        check("rst_tuser", (DW+2)'(m_axis_tuser), '0);
        check("rst_rd_en", (DW+2)'(buf_rd_en), '0);
        check("rst_busy", (DW+2)'(busy), '0);
        check("rst_overflow", (DW+2)'(credit_overflow), '0);
        check("rst_stall", (DW+2)'(stall_cycles), '0);
        aresetn = 1'b1;
        tick();

        // Single row: 4 consecutive strobes, first tvalid 2 cycles after
        // STREAM entry, busy falls afterwards.
        first_busy = -1; first_valid = -1; first_rd = -1; last_rd = -1; rd_cnt = 0;
        send_row(1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy && first_busy < 0) first_busy = k;
            if (m_axis_tvalid && first_valid < 0) first_valid = k;
            if (buf_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = k;
                last_rd = k;
            end
        end
        tick();
        check("t1_rd_count", (DW+2)'(rd_cnt), (DW+2)'(BEATS));
        check("t1_rd_consecutive", (DW+2)'(last_rd - first_rd), (DW+2)'(BEATS - 1));
        check("t1_rd_at_stream", (DW+2)'(first_rd == first_busy && first_busy >= 0), (DW+2)'(1));
        check("t1_latency", (DW+2)'(first_valid - first_busy), (DW+2)'(2));
        check("t1_busy_low", (DW+2)'(busy), '0);
        check("t1_rows", (DW+2)'(rows_out), (DW+2)'(1));

        // Two back-to-back rows.
        hs0 = hs_cnt; rows0 = rows_out;
        send_row(1'b1);
        send_row(1'b1);
        wait_idle("t2_idle", 100);
        check("t2_beats", (DW+2)'(hs_cnt - hs0), (DW+2)'(2 * BEATS));
        check("t2_rows", (DW+2)'(rows_out - rows0), (DW+2)'(2));

        // tready toggling 1,0,0,1 while a row streams.
        s0 = int'(stall_cycles); w0 = stall_seen; hs0 = hs_cnt;
        pat = 4'b1001;
        send_row(1'b1);
        cyc = 0;
        while (!(exp_q.size() == 0 && !busy) && cyc < 200) begin
            m_axis_tready = pat[cyc % 4];
            tick();
            cyc++;
        end
        m_axis_tready = 1'b1;
        check("t3_idle", (DW+2)'(cyc < 200), (DW+2)'(1));
        check("t3_beats", (DW+2)'(hs_cnt - hs0), (DW+2)'(BEATS));
        check("t3_stalls_seen", (DW+2)'(stall_seen - w0 > 0), (DW+2)'(1));
`ifdef ROW_READER_STATS_EN
        check("t3_stall_delta", (DW+2)'(int'(stall_cycles) - s0), (DW+2)'(stall_seen - w0));
`else
        check("t3_stall_zero", (DW+2)'(stall_cycles), '0);
`endif

        // Credit overflow with tready held low: one row in progress, two
        // queued credits, the fourth pulse is dropped.
        rows0 = rows_out;
        m_axis_tready = 1'b0;
        send_row(1'b1);
        repeat (3) tick();
        send_row(1'b1);
        send_row(1'b1);
        check("t4_no_overflow_yet", (DW+2)'(credit_overflow), '0);
        send_row(1'b0);
        check("t4_overflow", (DW+2)'(credit_overflow), (DW+2)'(1));
        repeat (3) tick();
        m_axis_tready = 1'b1;
        wait_idle("t4_idle", 200);
        check("t4_rows", (DW+2)'(rows_out - rows0), (DW+2)'(3));
        check("t4_overflow_sticky", (DW+2)'(credit_overflow), (DW+2)'(1));

        // 65 rows from a fresh frame: tuser on row 0 and again on row 64.
        do_reset();
        check("t5_overflow_cleared", (DW+2)'(credit_overflow), '0);
        rows0 = rows_out; user0 = user_seen; sent = 0; timeout = 1'b0;
        while (sent < DIM + 1 && !timeout) begin
            cyc = 0;
            while (sent - (rows_out - rows0) > 1 && cyc < 100) begin
                tick();
                cyc++;
            end
            if (cyc >= 100) timeout = 1'b1;
            send_row(1'b1);
            sent++;
        end
        check("t5_throttle", (DW+2)'(timeout), '0);
        wait_idle("t5_idle", 200);
        check("t5_rows", (DW+2)'(rows_out - rows0), (DW+2)'(DIM + 1));
        check("t5_tuser_count", (DW+2)'(user_seen - user0), (DW+2)'(2));

        // Random backpressure and random row arrival.
        rows0 = rows_out; sent = 0; cyc = 0;
        while ((sent < 30 || !(exp_q.size() == 0 && !busy)) && cyc < 4000) begin
            m_axis_tready = ($urandom_range(0, 9) < 7);
            if (sent < 30 && (sent - (rows_out - rows0)) <= 1 && $urandom_range(0, 3) == 0) begin
                send_row(1'b1);
                sent++;
            end else begin
                tick();
            end
            cyc++;
        end
        m_axis_tready = 1'b1;
        check("t6_done", (DW+2)'(cyc < 4000), (DW+2)'(1));
        check("t6_rows", (DW+2)'(rows_out - rows0), (DW+2)'(30));

        // Reset mid-row during a stall, then a clean row with tuser.
        m_axis_tready = 1'b0;
        send_row(1'b1);
        repeat (4) tick();
        check("t7_stalled", (DW+2)'(m_axis_tvalid), (DW+2)'(1));
        aresetn = 1'b0;
        #1;
        check("t7_rst_tvalid", (DW+2)'(m_axis_tvalid), '0);
        check("t7_rst_tdata", (DW+2)'(m_axis_tdata), '0);
        check("t7_rst_tlast", (DW+2)'(m_axis_tlast), '0);
        check("t7_rst_tuser", (DW+2)'(m_axis_tuser), '0);
        check("t7_rst_rd_en", (DW+2)'(buf_rd_en), '0);
        check("t7_rst_busy", (DW+2)'(busy), '0);
        check("t7_rst_stall", (DW+2)'(stall_cycles), '0);
        exp_q.delete();
        model_row = 0;
        tick();
        tick();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        hs0 = hs_cnt; user0 = user_seen;
        send_row(1'b1);
        wait_idle("t7_idle", 100);
        check("t7_beats", (DW+2)'(hs_cnt - hs0), (DW+2)'(BEATS));
        check("t7_tuser", (DW+2)'(user_seen - user0), (DW+2)'(1));

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
